// File: rtl/pool2x2_stream_if.sv
// pool2x2_stream_if: pixel stream in, pooled stream out, plus per-frame mode and error flag.
interface pool2x2_stream_if #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 8
);
   logic [IN_W-1:0]  s_pixel;
   logic             s_valid;
   logic             s_sof;
   logic             s_ready;
   logic             mode_max;
   logic [OUT_W-1:0] m_pixel;
   logic             m_valid;
   logic             m_ready;
   logic             m_last;
   logic             m_eof;
   logic             frame_err;
   modport master (
      output s_pixel, s_valid, s_sof, mode_max, m_ready,
      input  s_ready, m_pixel, m_valid, m_last, m_eof, frame_err
   );
   modport slave (
      input  s_pixel, s_valid, s_sof, mode_max, m_ready,
      output s_ready, m_pixel, m_valid, m_last, m_eof, frame_err
   );
endinterface

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: streaming 2x2 stride-2 average/max pooling with a single line buffer.
module pool2x2_stream #(
   parameter int IMG_W = 62,
   parameter int IMG_H = 62,
   parameter int IN_W  = 12,
   parameter int OUT_W = 8
) (
   input  logic             clk_200mhz,
   input  logic             reset_n,
   pool2x2_stream_if.slave  bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0]   COL_END  = CW'(IMG_W - 1);
   localparam logic [CW-1:0]   COL_LAST = CW'(2 * (IMG_W / 2) - 1);
   localparam logic [RW-1:0]   ROW_END  = RW'(IMG_H - 1);
   localparam logic [RW-1:0]   ROW_LAST = RW'(2 * (IMG_H / 2) - 1);
   localparam logic [IN_W-1:0] OMAX     = IN_W'((2 ** OUT_W) - 1);

   logic [IN_W-1:0] line_buf [IMG_W];
   logic [CW-1:0]   col, ccol;
   logic [RW-1:0]   row, crow;
   logic            first_px, mode_q, mode_c, acc, resync, fire, wlast, weof;
   logic [IN_W-1:0] top_prev, bot_prev, top_cur;
   logic            v1, mode1, last1, eof1;
   logic [IN_W:0]   a1, b1, a_n, b_n;
   logic [IN_W+1:0] sum;
   logic [IN_W-1:0] avg, mx, res;

   // An accepted s_sof forces the pixel to position (0,0) regardless of the counters.
   always_comb begin
      bus.s_ready = !(bus.m_valid && !bus.m_ready);
      acc     = bus.s_valid && bus.s_ready;
      ccol    = bus.s_sof ? '0 : col;
      crow    = bus.s_sof ? '0 : row;
      resync  = acc && bus.s_sof && (col != '0 || row != '0);
      mode_c  = (bus.s_sof || first_px) ? bus.mode_max : mode_q;
      fire    = acc && crow[0] && ccol[0] && ccol <= COL_LAST && crow <= ROW_LAST;
      wlast   = ccol == COL_LAST;
      weof    = wlast && crow == ROW_LAST;
      top_cur = line_buf[ccol];
      a_n     = mode_c ? {1'b0, (top_prev > top_cur ? top_prev : top_cur)}
                       : (IN_W+1)'(top_prev) + (IN_W+1)'(top_cur);
      b_n     = mode_c ? {1'b0, (bot_prev > bus.s_pixel ? bot_prev : bus.s_pixel)}
                       : (IN_W+1)'(bot_prev) + (IN_W+1)'(bus.s_pixel);
      sum     = (IN_W+2)'(a1) + (IN_W+2)'(b1) + (IN_W+2)'(2);
      avg     = sum[IN_W+1:2];
      mx      = a1 > b1 ? a1[IN_W-1:0] : b1[IN_W-1:0];
      res     = mode1 ? mx : avg;
   end

   // Even rows fill the line buffer; even columns of odd rows park the left half of a window.
   always_ff @(posedge clk_200mhz) begin
      if (acc && !crow[0]) line_buf[ccol] <= bus.s_pixel;
      if (acc && crow[0] && !ccol[0]) begin
         top_prev <= top_cur;
         bot_prev <= bus.s_pixel;
      end
   end

   always_ff @(posedge clk_200mhz or negedge reset_n) begin
      if (!reset_n) begin
         col           <= '0;
         row           <= '0;
         first_px      <= 1'b1;
         mode_q        <= 1'b0;
         v1            <= 1'b0;
         a1            <= '0;
         b1            <= '0;
         mode1         <= 1'b0;
         last1         <= 1'b0;
         eof1          <= 1'b0;
         bus.m_valid   <= 1'b0;
         bus.m_pixel   <= '0;
         bus.m_last    <= 1'b0;
         bus.m_eof     <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         bus.frame_err <= resync;
         if (acc) begin
            col      <= ccol == COL_END ? '0 : ccol + 1'b1;
            row      <= ccol == COL_END ? (crow == ROW_END ? '0 : crow + 1'b1) : crow;
            mode_q   <= mode_c;
            first_px <= 1'b0;
         end
         if (bus.s_ready) begin
            v1          <= fire;
            bus.m_valid <= v1;
            if (fire) begin
               a1    <= a_n;
               b1    <= b_n;
               mode1 <= mode_c;
               last1 <= wlast;
               eof1  <= weof;
            end
            if (v1) begin
               bus.m_pixel <= res > OMAX ? OMAX[OUT_W-1:0] : res[OUT_W-1:0];
               bus.m_last  <= last1;
               bus.m_eof   <= eof1;
            end
         end
      end
   end
endmodule

// File: tb/tb_pool2x2_stream.sv
// tb_pool2x2_stream: directed checks of 2x2 pooling on 4x4 and 5x5 images with backpressure.
module tb_pool2x2_stream;
   logic clk_200mhz = 1'b0;
   logic reset_n    = 1'b0;
   always #5 clk_200mhz = !clk_200mhz;

   pool2x2_stream_if #(.IN_W(12), .OUT_W(8)) bus ();
   pool2x2_stream_if #(.IN_W(12), .OUT_W(8)) bus5 ();

   pool2x2_stream #(.IMG_W(4), .IMG_H(4), .IN_W(12), .OUT_W(8)) dut (
      .clk_200mhz(clk_200mhz), .reset_n(reset_n), .bus(bus));
   pool2x2_stream #(.IMG_W(5), .IMG_H(5), .IN_W(12), .OUT_W(8)) dut5 (
      .clk_200mhz(clk_200mhz), .reset_n(reset_n), .bus(bus5));

   int n_chk = 0, n_err = 0, ferr_cnt = 0, held = 0;
   int exp_q[$];
   int got5[$];
   bit rnd_on = 1'b0, stall_d = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int pool(input int a, input int b, input int c, input int d, input bit mx);
      int r;
      r = mx ? ((a > b ? a : b) > (c > d ? c : d) ? (a > b ? a : b) : (c > d ? c : d))
             : (a + b + c + d + 2) >> 2;
      return r > 255 ? 255 : r;
   endfunction

   task automatic push_exp(input int p, input int l, input int e);
      exp_q.push_back(p | (l << 8) | (e << 9));
   endtask

   task automatic expect_frame(input int f[16], input bit mx);
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            push_exp(pool(f[8*i+2*j], f[8*i+2*j+1], f[8*i+2*j+4], f[8*i+2*j+5], mx),
                     j, (i == 1 && j == 1) ? 1 : 0);
   endtask

   task automatic send(input int px, input bit sof);
      int t = 0;
      bus.s_pixel = 12'(px);
      bus.s_sof   = sof;
      bus.s_valid = 1'b1;
      @(negedge clk_200mhz);
      while (!bus.s_ready && t < 200) begin
         @(negedge clk_200mhz);
         t++;
      end
      if (t >= 200) check("s_ready_timeout", 0, 1);
      @(posedge clk_200mhz);
      #1;
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
   endtask

   // The mode input is flipped right after the first pixel to confirm it is held per frame.
   task automatic send_frame(input int f[16], input bit mx, input bit gap);
      bus.mode_max = mx;
      for (int k = 0; k < 16; k++) begin
         if (gap && $urandom_range(9) >= 7) begin
            @(posedge clk_200mhz);
            #1;
         end
         send(f[k], k == 0);
         if (k == 0) bus.mode_max = !mx;
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(posedge clk_200mhz);
         t++;
      end
      #1;
      check("drain", exp_q.size(), 0);
   endtask

   always @(posedge clk_200mhz) begin
      #1;
      if (rnd_on) bus.m_ready = 1'($urandom_range(1));
   end

   always @(negedge clk_200mhz) begin
      int cur;
      cur = int'({bus.m_eof, bus.m_last, bus.m_pixel});
      if (bus.frame_err) ferr_cnt++;
      if (stall_d) begin
         check("stall_valid", int'(bus.m_valid), 1);
         check("stall_hold", cur, held);
      end
      stall_d = bus.m_valid && !bus.m_ready;
      held    = cur;
      if (bus.m_valid && bus.m_ready) begin
         if (exp_q.size() == 0) check("extra_out", cur, -1);
         else check("out", cur, exp_q.pop_front());
      end
      if (bus5.m_valid && bus5.m_ready)
         got5.push_back(int'({bus5.m_eof, bus5.m_last, bus5.m_pixel}));
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int fa[16] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 110, 120, 130, 140, 150, 160};
      int fm[16] = '{3, 900, 3, 200, 7, 2, 7, 2, 1, 2, 3, 4, 5, 6, 7, 8};
      int fc[16] = '{1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 2, 2, 0, 0, 2, 1};
      int exp5[4] = '{3, 261, 13, 783};
      int fs[16];
      int fr[16];
      int f0;
      foreach (fs[i]) fs[i] = 4095;
      bus.s_pixel = '0;  bus.s_valid = 1'b0;  bus.s_sof = 1'b0;  bus.mode_max = 1'b0;  bus.m_ready = 1'b1;
      bus5.s_pixel = '0; bus5.s_valid = 1'b0; bus5.s_sof = 1'b0; bus5.mode_max = 1'b0; bus5.m_ready = 1'b1;
      repeat (2) @(posedge clk_200mhz);
      #1;
      check("rst_m_valid", int'(bus.m_valid), 0);
      check("rst_m_pixel", int'(bus.m_pixel), 0);
      check("rst_m_last", int'(bus.m_last), 0);
      check("rst_m_eof", int'(bus.m_eof), 0);
      check("rst_frame_err", int'(bus.frame_err), 0);
      check("rst_s_ready", int'(bus.s_ready), 1);
      reset_n = 1'b1;
      @(posedge clk_200mhz);
      #1;
      // average frame with a latency probe on the first window
      push_exp(35, 0, 0); push_exp(55, 1, 0); push_exp(115, 0, 0); push_exp(135, 1, 1);
      for (int k = 0; k < 6; k++) send(fa[k], k == 0);
      check("lat_stage1", int'(bus.m_valid), 0);
      @(posedge clk_200mhz);
      #1;
      check("lat_valid", int'(bus.m_valid), 1);
      check("lat_pixel", int'(bus.m_pixel), 35);
      for (int k = 6; k < 16; k++) send(fa[k], 1'b0);
      // back-to-back: saturation, max mode, rounding
      push_exp(255, 0, 0); push_exp(255, 1, 0); push_exp(255, 0, 0); push_exp(255, 1, 1);
      send_frame(fs, 1'b0, 1'b0);
      push_exp(255, 0, 0); push_exp(200, 1, 0); push_exp(6, 0, 0); push_exp(8, 1, 1);
      send_frame(fm, 1'b1, 1'b0);
      push_exp(1, 0, 0); push_exp(0, 1, 0); push_exp(1, 0, 0); push_exp(2, 1, 1);
      send_frame(fc, 1'b0, 1'b0);
      drain();
      check("no_frame_err", ferr_cnt, 0);
      // random backpressure and input gaps over three frames
      rnd_on = 1'b1;
      for (int n = 0; n < 3; n++) begin
         foreach (fr[i]) fr[i] = int'($urandom_range(4095));
         expect_frame(fr, n == 1);
         send_frame(fr, n == 1, 1'b1);
      end
      rnd_on = 1'b0;
      bus.m_ready = 1'b1;
      drain();
      // s_sof on the sixth pixel of a frame
      f0 = ferr_cnt;
      for (int k = 0; k < 5; k++) send(0, k == 0);
      push_exp(35, 0, 0); push_exp(55, 1, 0); push_exp(115, 0, 0); push_exp(135, 1, 1);
      send_frame(fa, 1'b0, 1'b0);
      drain();
      check("frame_err_pulse", ferr_cnt - f0, 1);
      // reset mid-frame, then a frame with no s_sof in max mode
      for (int k = 0; k < 5; k++) send(fa[k], k == 0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_m_valid", int'(bus.m_valid), 0);
      check("mid_rst_m_pixel", int'(bus.m_pixel), 0);
      check("mid_rst_m_last", int'(bus.m_last), 0);
      check("mid_rst_m_eof", int'(bus.m_eof), 0);
      check("mid_rst_s_ready", int'(bus.s_ready), 1);
      repeat (3) @(posedge clk_200mhz);
      #1;
      reset_n = 1'b1;
      bus.mode_max = 1'b1;
      push_exp(255, 0, 0); push_exp(200, 1, 0); push_exp(6, 0, 0); push_exp(8, 1, 1);
      for (int k = 0; k < 16; k++) begin
         send(fm[k], 1'b0);
         if (k == 0) bus.mode_max = 1'b0;
      end
      drain();
      // odd 5x5 image: trailing column and row are dropped
      for (int k = 0; k < 25; k++) begin
         bus5.s_pixel = 12'(k);
         bus5.s_sof   = k == 0;
         bus5.s_valid = 1'b1;
         @(posedge clk_200mhz);
         #1;
      end
      bus5.s_valid = 1'b0;
      bus5.s_sof   = 1'b0;
      repeat (5) @(posedge clk_200mhz);
      #1;
      check("odd_count", got5.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < got5.size()) check("odd_out", got5[i], exp5[i]);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
